// File: rtl/framed_shift_register.sv
// framed_shift_register
//   Full-duplex frame serializer/deserializer. A WIDTH-bit word is taken on a
//   valid/ready port, shifted out one bit per shift_en strobe while the
//   returning serial bits are shifted into the same buffer, and the completed
//   received word is presented on rx_data with a one-cycle rx_valid pulse.
//
// Parameters
//   WIDTH     : frame length in bits (>= 2)
//   LSB_FIRST : 0 = MSB first (receive into bit 0), 1 = LSB first (receive into bit WIDTH-1)
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   shift_en   in   bit strobe, one shift per high cycle while busy
//   abort      in   synchronous frame cancel (beats shift and load)
//   serial_in  in   received bit, sampled on the shift edge
//   serial_out out  transmitted bit, 0 when idle
//   tx_data    in   word to send
//   tx_valid   in   tx_data is valid
//   tx_ready   out  word accepted this cycle when tx_valid is high
//   rx_data    out  last completed received word
//   rx_valid   out  one-cycle pulse, rx_data updated
//   busy       out  frame in progress
module framed_shift_register #(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             abort,
  input  logic             serial_in,
  output logic             serial_out,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_buffer;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_rx_data;
  logic             r_rx_valid;

  logic             w_busy;
  logic             w_last;
  logic             w_ready;
  logic             w_load;
  logic [WIDTH-1:0] w_shifted;

  assign w_busy  = (r_state == SHIFT);
  assign w_last  = w_busy && shift_en && (r_count == CW'(WIDTH - 1));
  // Ready is combinational so a new word can be taken on the very edge that
  // shifts the last bit, giving back-to-back frames with no idle cycle.
  assign w_ready = !rst && !abort && (!w_busy || w_last);
  assign w_load  = tx_valid && w_ready;

  always_comb begin
    w_shifted = r_buffer;
    if (LSB_FIRST != 0) begin
      w_shifted = {serial_in, r_buffer[WIDTH-1:1]};
    end else begin
      w_shifted = {r_buffer[WIDTH-2:0], serial_in};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_buffer   <= '0;
      r_count    <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (abort) begin
        r_state <= IDLE;
        r_count <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_load) begin
              r_buffer <= tx_data;
              r_count  <= '0;
              r_state  <= SHIFT;
            end
          end
          SHIFT: begin
            if (shift_en) begin
              if (w_last) begin
                r_rx_data  <= w_shifted;
                r_rx_valid <= 1'b1;
                if (w_load) begin
                  r_buffer <= tx_data;
                  r_count  <= '0;
                end else begin
                  r_buffer <= w_shifted;
                  r_count  <= '0;
                  r_state  <= IDLE;
                end
              end else begin
                r_buffer <= w_shifted;
                r_count  <= r_count + 1'b1;
              end
            end
          end
          default: begin
            r_state <= IDLE;
            r_count <= '0;
          end
        endcase
      end
    end
  end

  assign busy       = w_busy;
  assign tx_ready   = w_ready;
  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign serial_out = w_busy ? ((LSB_FIRST != 0) ? r_buffer[0] : r_buffer[WIDTH-1]) : 1'b0;

endmodule

// File: tb/tb_framed_shift_register.sv
// Bench for framed_shift_register: an MSB-first and an LSB-first instance run
// side by side on shared stimulus; received words are checked by a scoreboard.
module tb_framed_shift_register;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       shift_en = 1'b0;
  logic       abort = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       sbit = 1'b0;
  logic       loop = 1'b0;

  logic       so_m, so_l, sin_m, sin_l, rdy_m, rdy_l, rv_m, rv_l, busy_m, busy_l;
  logic [7:0] rd_m, rd_l;

  int         duty = 100;
  logic [7:0] stream = 8'h00;
  int         n_checks = 0;
  int         n_err = 0;
  logic [7:0] q_m[$];
  logic [7:0] q_l[$];
  logic [7:0] last_m = 8'h00;
  logic [7:0] last_l = 8'h00;

  assign sin_m = loop ? so_m : sbit;
  assign sin_l = loop ? so_l : sbit;

  always #5 clk = ~clk;

  framed_shift_register #(.WIDTH(8), .LSB_FIRST(0)) u_msb (
    .clk(clk), .rst(rst), .shift_en(shift_en), .abort(abort),
    .serial_in(sin_m), .serial_out(so_m), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdy_m), .rx_data(rd_m), .rx_valid(rv_m), .busy(busy_m)
  );

  framed_shift_register #(.WIDTH(8), .LSB_FIRST(1)) u_lsb (
    .clk(clk), .rst(rst), .shift_en(shift_en), .abort(abort),
    .serial_in(sin_l), .serial_out(so_l), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdy_l), .rx_data(rd_l), .rx_valid(rv_l), .busy(busy_l)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  // Expected received word: loopback returns the sent word; otherwise the
  // stream (listed first bit = bit 7) lands as-is MSB-first, reversed LSB-first.
  function automatic logic [7:0] em(input logic [7:0] d);
    return loop ? d : stream;
  endfunction
  function automatic logic [7:0] el(input logic [7:0] d);
    return loop ? d : rev8(stream);
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [7:0] e;
    if (rv_m) begin
      if (q_m.size() == 0) chk("rx_valid_m_unexpected", {24'h0, rd_m}, 32'hFFFF_FFFF);
      else begin
        e = q_m.pop_front();
        chk("rx_data_m", {24'h0, rd_m}, {24'h0, e});
        last_m = e;
      end
    end
    if (rv_l) begin
      if (q_l.size() == 0) chk("rx_valid_l_unexpected", {24'h0, rd_l}, 32'hFFFF_FFFF);
      else begin
        e = q_l.pop_front();
        chk("rx_data_l", {24'h0, rd_l}, {24'h0, e});
        last_l = e;
      end
    end
  end

  task automatic load(input logic [7:0] d, input bit push);
    @(negedge clk);
    tx_valid = 1'b1; tx_data = d; shift_en = 1'b0; abort = 1'b0;
    #1;
    chk("ready_idle_m", rdy_m, 1); chk("ready_idle_l", rdy_l, 1);
    chk("busy_idle_m", busy_m, 0); chk("busy_idle_l", busy_l, 0);
    if (push) begin q_m.push_back(em(d)); q_l.push_back(el(d)); end
  endtask

  task automatic shift_frame(input logic [7:0] d, input int nbits, input bit chain,
                             input logic [7:0] nd, input bit pulse);
    int i = 0;
    int cyc = 0;
    bit se;
    while (i < nbits) begin
      @(negedge clk);
      if (cyc >= 2000) begin
        n_checks++; n_err++;
        $display("FAIL shift_timeout: got %0d shifts expected %0d", i, nbits);
        break;
      end
      se = (duty >= 100) || ($urandom_range(99) < duty);
      shift_en = se; sbit = stream[7-i]; tx_valid = chain; tx_data = nd;
      #1;
      chk("busy_m", busy_m, 1); chk("busy_l", busy_l, 1);
      chk("sout_m", so_m, d[7-i]); chk("sout_l", so_l, d[i]);
      chk("ready_m", rdy_m, (se && i == 7)); chk("ready_l", rdy_l, (se && i == 7));
      if (cyc == 0) begin chk("pulse_m", rv_m, pulse); chk("pulse_l", rv_l, pulse); end
      if (se && i == 7 && chain) begin q_m.push_back(em(nd)); q_l.push_back(el(nd)); end
      if (se) i++;
      cyc++;
    end
  endtask

  task automatic finish_frame();
    @(negedge clk);
    shift_en = 1'b0; tx_valid = 1'b0; sbit = 1'b0;
    #1;
    chk("done_busy_m", busy_m, 0); chk("done_busy_l", busy_l, 0);
    chk("done_sout_m", so_m, 0); chk("done_sout_l", so_l, 0);
    chk("done_rv_m", rv_m, 1); chk("done_rv_l", rv_l, 1);
    @(negedge clk);
    #1;
    chk("rv_drop_m", rv_m, 0); chk("rv_drop_l", rv_l, 0);
  endtask

  task automatic abort_step();
    @(negedge clk);
    abort = 1'b1; shift_en = 1'b1; tx_valid = 1'b1; tx_data = 8'hEE;
    #1;
    chk("abort_ready_m", rdy_m, 0); chk("abort_ready_l", rdy_l, 0);
    @(negedge clk);
    abort = 1'b0; shift_en = 1'b0; tx_valid = 1'b0;
    #1;
    chk("abort_busy_m", busy_m, 0); chk("abort_busy_l", busy_l, 0);
    chk("abort_sout_m", so_m, 0); chk("abort_sout_l", so_l, 0);
    chk("abort_ready_idle_m", rdy_m, 1);
    chk("abort_rxhold_m", rd_m, last_m); chk("abort_rxhold_l", rd_l, last_l);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_busy_m"}, busy_m, 0); chk({tag, "_busy_l"}, busy_l, 0);
    chk({tag, "_sout_m"}, so_m, 0); chk({tag, "_sout_l"}, so_l, 0);
    chk({tag, "_ready_m"}, rdy_m, 0); chk({tag, "_ready_l"}, rdy_l, 0);
    chk({tag, "_rv_m"}, rv_m, 0); chk({tag, "_rv_l"}, rv_l, 0);
    chk({tag, "_rd_m"}, rd_m, 0); chk({tag, "_rd_l"}, rd_l, 0);
  endtask

  initial begin
    logic [7:0] vec [4];
    vec[0] = 8'hA5; vec[1] = 8'h00; vec[2] = 8'hFF; vec[3] = 8'h81;

    #1 rst = 1'b1;
    #1 reset_checks("reset");
    @(negedge clk);
    rst = 1'b0;
    #1 chk("ready_after_reset", rdy_m, 1);

    // Fixed stream 0,0,1,1,1,1,0,0 against word 0x0F on both bit orders
    loop = 1'b0; stream = 8'h3C; duty = 100;
    load(8'h0F, 1);
    shift_frame(8'h0F, 8, 0, 8'h00, 0);
    finish_frame();

    // Loopback with gappy strobe
    loop = 1'b1; duty = 30;
    for (int k = 0; k < 4; k++) begin
      load(vec[k], 1);
      shift_frame(vec[k], 8, 0, 8'h00, 0);
      finish_frame();
    end

    // Back-to-back frames
    duty = 100;
    load(8'h12, 1);
    shift_frame(8'h12, 8, 1, 8'h34, 0);
    shift_frame(8'h34, 8, 0, 8'h00, 1);
    finish_frame();

    // Abort after three shifts, then a clean frame
    load(8'hC3, 0);
    shift_frame(8'hC3, 3, 0, 8'h00, 0);
    abort_step();
    load(8'h5A, 1);
    shift_frame(8'h5A, 8, 0, 8'h00, 0);
    finish_frame();

    // Abort coinciding with the last bit
    load(8'h77, 0);
    shift_frame(8'h77, 7, 0, 8'h00, 0);
    abort_step();

    // Asynchronous reset mid-frame
    load(8'h99, 0);
    shift_frame(8'h99, 4, 0, 8'h00, 0);
    @(negedge clk);
    shift_en = 1'b1; tx_valid = 1'b0;
    #2 rst = 1'b1;
    #1 reset_checks("midrst");
    last_m = 8'h00; last_l = 8'h00;
    @(negedge clk);
    #1 reset_checks("midrst_hold");
    rst = 1'b0; shift_en = 1'b0;
    load(8'h66, 1);
    shift_frame(8'h66, 8, 0, 8'h00, 0);
    finish_frame();

    repeat (3) @(negedge clk);
    chk("queue_m_empty", q_m.size(), 0);
    chk("queue_l_empty", q_l.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
